flush_redirect_ctrl: RTL and testbench

//  Central flush/redirect sequencer between WB+CSR and the front end.
//  - Accepts commit-time events from WB: exception, ertn, TLB refetch.
//  - Kills younger instructions in IF/ID/EX/MEM.
//  - Drains stale in-flight instruction-fetch responses.
//  - Hands one redirect PC to IF over a valid/ready handshake.

---
 rtl/flush_redirect_ctrl.sv | 157 +++++++++++++++
 tb/tb_flush_redirect_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/flush_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// flush_redirect_ctrl
//
// Central flush/redirect sequencer between the WB/CSR stage and the front end.
// A commit-time event (exception, ertn or TLB refetch) kills all younger work
// in IF/ID/EX/MEM. Fetch responses that are still in flight are drained and
// discarded. One redirect PC is then handed to IF over a valid/ready
// handshake.
//
// Build option:
//   FLUSH_CTRL_PERF_EN - adds the perf_flush_cnt and perf_discard_cnt outputs
//                        and their counters. Without it the ports are absent.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   wb_ex               exception committing at WB (qualified)
//   ertn_flush          ertn committing at WB (qualified)
//   refetch             TLB-op refetch committing at WB (qualified)
//   ex_entry            exception target from CSR
//   era                 ertn target (CSR.ERA)
//   refetch_entry       PC of the refetch instruction
//   if_req_issued       IF fetch request accepted by the bus this cycle
//   if_resp_valid       fetch response returns this cycle
//   if_redirect_ready   IF accepts the redirect this cycle
//   flush_all           invalidate IF/ID/EX/MEM; block new fetch issue
//   if_resp_discard     drop the response returning this cycle
//   redirect_valid      redirect offered to IF
//   redirect_pc         redirect target, stable while redirect_valid
//   busy                sequencer is not idle
//   perf_flush_cnt      accepted events (FLUSH_CTRL_PERF_EN only)
//   perf_discard_cnt    discarded responses (FLUSH_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module flush_redirect_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic        refetch,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era,
    input  logic [31:0] refetch_entry,
    input  logic        if_req_issued,
    input  logic        if_resp_valid,
    input  logic        if_redirect_ready,
    output logic        flush_all,
    output logic        if_resp_discard,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
`ifdef FLUSH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   tgt;

    // Saturating up/down step: held at MAX_OUTSTANDING and at 0, so a
    // protocol slip by IF can never wrap the count.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                               input logic          inc,
                                               input logic          dec);
        logic [CW-1:0] max_v;
        max_v = CW'(MAX_OUTSTANDING);
        if (inc && !dec && (cnt != max_v))
            return cnt + 1'b1;
        else if (dec && !inc && (cnt != '0))
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    logic          event_in;
    logic          accept;
    logic [31:0]   tgt_sel;
    logic [CW-1:0] out_next;
    logic [CW-1:0] drop_next;

    assign event_in = wb_ex | ertn_flush | refetch;
    // Events only matter in IDLE; elsewhere WB is already flushed.
    assign accept   = (state == IDLE) && event_in;
    assign tgt_sel  = wb_ex      ? ex_entry :
                      ertn_flush ? era      : refetch_entry;
    assign out_next = cnt_step(out_cnt, if_req_issued, if_resp_valid);
    // On the event cycle the drop count seeds from the live outstanding
    // count, including this cycle's issue/response.
    assign drop_next = cnt_step((state == IDLE) ? out_cnt : drop_cnt,
                                if_req_issued, if_resp_valid);

    // The event-cycle outputs are combinational from WB inputs; gating them
    // with reset keeps every output low while reset is held.
    assign flush_all       = !reset && (accept || (state != IDLE));
    assign if_resp_discard = !reset && if_resp_valid &&
                             (accept || (state == DRAIN));
    assign redirect_valid  = (state == REDIRECT);
    assign redirect_pc     = tgt;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            out_cnt  <= '0;
            drop_cnt <= '0;
            tgt      <= '0;
        end else begin
            out_cnt <= out_next;
            case (state)
                IDLE: begin
                    if (event_in) begin
                        tgt      <= tgt_sel;
                        drop_cnt <= drop_next;
                        state    <= (drop_next != '0) ? DRAIN : REDIRECT;
                    end
                end
                DRAIN: begin
                    drop_cnt <= drop_next;
                    if (drop_next == '0)
                        state <= REDIRECT;
                end
                REDIRECT: begin
                    if (if_redirect_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FLUSH_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_flush_cnt   <= '0;
            perf_discard_cnt <= '0;
        end else begin
            if (accept)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (if_resp_discard)
                perf_discard_cnt <= perf_discard_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
module tb_flush_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex, ertn_flush, refetch;
    logic [31:0] ex_entry, era, refetch_entry;
    logic        if_req_issued, if_resp_valid, if_redirect_ready;
    logic        flush_all, if_resp_discard, redirect_valid, busy;
    logic [31:0] redirect_pc;
`ifdef FLUSH_CTRL_PERF_EN
    logic [31:0] perf_flush_cnt, perf_discard_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_flush = 0;
    int exp_disc  = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] held_pc;

    always #5 clk = ~clk;

    flush_redirect_ctrl #(.MAX_OUTSTANDING(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .refetch           (refetch),
        .ex_entry          (ex_entry),
        .era               (era),
        .refetch_entry     (refetch_entry),
        .if_req_issued     (if_req_issued),
        .if_resp_valid     (if_resp_valid),
        .if_redirect_ready (if_redirect_ready),
        .flush_all         (flush_all),
        .if_resp_discard   (if_resp_discard),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy)
`ifdef FLUSH_CTRL_PERF_EN
        ,
        .perf_flush_cnt    (perf_flush_cnt),
        .perf_discard_cnt  (perf_discard_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at
    // the falling edge so the caller samples settled outputs.
    task automatic cyc(input logic ex, input logic ertn, input logic rf,
                       input logic iss, input logic resp, input logic rdy);
        @(posedge clk);
        #1;
        wb_ex             = ex;
        ertn_flush        = ertn;
        refetch           = rf;
        if_req_issued     = iss;
        if_resp_valid     = resp;
        if_redirect_ready = rdy;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic fl, input logic disc,
                           input logic vld, input logic bsy);
        check_val({tag, "_flush"},   flush_all,       fl);
        check_val({tag, "_discard"}, if_resp_discard, disc);
        check_val({tag, "_rvalid"},  redirect_valid,  vld);
        check_val({tag, "_busy"},    busy,            bsy);
    endtask

    // Scoreboard: every accepted redirect handshake pops one expected PC.
    always @(negedge clk) begin
        if (!reset && redirect_valid && if_redirect_ready) begin
            check_val("sb_has_entry", (exp_pc_q.size() != 0), 1);
            if (exp_pc_q.size() != 0)
                check_val("sb_redirect_pc", redirect_pc, exp_pc_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wb_ex = 0; ertn_flush = 0; refetch = 0;
        if_req_issued = 0; if_resp_valid = 0; if_redirect_ready = 0;
        ex_entry = 32'h1c00_8000; era = 32'h1c00_0100; refetch_entry = 32'h1c00_00a0;
        repeat (2) @(negedge clk);
        chk_out("rst", 0, 0, 0, 0);
        check_val("rst_pc", redirect_pc, 32'h0);
        reset = 1'b0;

        // 1: exception with nothing outstanding -> redirect next cycle
        cyc(1, 0, 0, 0, 0, 0);
        chk_out("t1_c0", 1, 0, 0, 0);
        exp_pc_q.push_back(32'h1c00_8000); exp_flush++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t1_c1", 1, 0, 1, 1);
        check_val("t1_pc", redirect_pc, 32'h1c00_8000);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t1_c2", 0, 0, 0, 0);

        // 2: ertn with two fetches outstanding -> drain both first
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk_out("t2_ev", 1, 0, 0, 0);
        exp_pc_q.push_back(32'h1c00_0100); exp_flush++;
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_wait", 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk_out("t2_resp1", 1, 1, 0, 1); exp_disc++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t2_mid", 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk_out("t2_resp2", 1, 1, 0, 1); exp_disc++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t2_redir", 1, 0, 1, 1);
        check_val("t2_pc", redirect_pc, 32'h1c00_0100);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_idle", 0, 0, 0, 0);

        // 3: exception beats refetch in the same cycle
        cyc(1, 0, 1, 0, 0, 0);
        chk_out("t3_ev", 1, 0, 0, 0);
        exp_pc_q.push_back(32'h1c00_8000); exp_flush++;
        cyc(0, 0, 0, 0, 0, 1);
        check_val("t3_pc", redirect_pc, 32'h1c00_8000);
        cyc(0, 0, 0, 0, 0, 0);

        // 4: event with issue+response together, one already outstanding
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        chk_out("t4_ev", 1, 1, 0, 0); exp_disc++;
        exp_pc_q.push_back(32'h1c00_00a0); exp_flush++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t4_drain", 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk_out("t4_resp", 1, 1, 0, 1); exp_disc++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t4_redir", 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t4_idle", 0, 0, 0, 0);

        // 5: redirect held while IF stalls
        ex_entry = 32'h1c00_4000;
        cyc(1, 0, 0, 0, 0, 0);
        exp_pc_q.push_back(32'h1c00_4000); exp_flush++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk_out("t5_hold", 1, 0, 1, 1);
            check_val("t5_pc", redirect_pc, 32'h1c00_4000);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t5_acc", 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t5_idle", 0, 0, 0, 0);
`ifdef FLUSH_CTRL_PERF_EN
        check_val("perf_flush", perf_flush_cnt, exp_flush);
        check_val("perf_disc",  perf_discard_cnt, exp_disc);
`endif

        // 6: reset in DRAIN aborts the sequence
        ex_entry = 32'h1c00_8000;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t6_drain", 1, 0, 0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1; wb_ex = 1'b1; if_resp_valid = 1'b1;
        #1;
        chk_out("t6_rst", 0, 0, 0, 0);
        check_val("t6_rst_pc", redirect_pc, 32'h0);
`ifdef FLUSH_CTRL_PERF_EN
        check_val("t6_perf_flush", perf_flush_cnt, 0);
        check_val("t6_perf_disc",  perf_discard_cnt, 0);
`endif
        exp_pc_q.delete();
        @(negedge clk);
        wb_ex = 1'b0; if_resp_valid = 1'b0; reset = 1'b0;
        exp_flush = 0; exp_disc = 0;
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t6_after", 0, 0, 0, 0);
        // out_cnt cleared: a fresh event must redirect without draining
        held_pc = 32'h1c00_0200;
        ex_entry = held_pc;
        cyc(1, 0, 0, 0, 0, 0);
        exp_pc_q.push_back(held_pc); exp_flush++;
        cyc(0, 0, 0, 0, 0, 1);
        chk_out("t6_redir", 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t6_idle", 0, 0, 0, 0);
`ifdef FLUSH_CTRL_PERF_EN
        check_val("t6_perf_flush_end", perf_flush_cnt, exp_flush);
`endif

        check_val("sb_empty", exp_pc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
